// File: rtl/spi_reg_sequencer_if.sv
// Request/response and spi_master-facing signals of the register-access sequencer.
// The slave modport is the sequencer's view; the master modport is the requester/SPI side.
interface spi_reg_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [6:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_err;
  logic [7:0] rsp_rdata;
  logic       seq_busy;
  logic       spi_start_n;
  logic [7:0] spi_data_in;
  logic       spi_busy;
  logic [7:0] spi_data_out;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, spi_busy, spi_data_out,
    output req_ready, rsp_valid, rsp_err, rsp_rdata, seq_busy, spi_start_n, spi_data_in
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, spi_busy, spi_data_out,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata, seq_busy, spi_start_n, spi_data_in
  );
endinterface

// File: rtl/spi_reg_sequencer.sv
// Register-access sequencer: turns one read/write request into an address byte and a
// data byte on an 8-bit spi_master, with start/busy timeouts and a fixed inter-byte gap.
module spi_reg_sequencer #(
  parameter int unsigned GAP_CYCLES    = 16,
  parameter int unsigned START_TIMEOUT = 1024,
  parameter int unsigned BUSY_TIMEOUT  = 200000000,
  parameter int unsigned CNT_W         = 32
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  spi_reg_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] BUSY_LAST  = CNT_W'(BUSY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_A_START, S_A_WAIT, S_GAP, S_D_START, S_D_WAIT, S_DONE, S_ERROR
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_write;
  logic [7:0]       r_wdata;
  logic             r_start_n;
  logic [7:0]       r_data_in;
  logic             r_rsp_valid;
  logic             r_rsp_err;
  logic [7:0]       r_rsp_rdata;
  logic             w_req_ready;

  // A master still finishing a byte blocks new requests even when we are idle.
  assign w_req_ready     = (r_state == S_IDLE) & ~bus.spi_busy;
  assign bus.req_ready   = w_req_ready;
  assign bus.seq_busy    = (r_state != S_IDLE);
  assign bus.spi_start_n = r_start_n;
  assign bus.spi_data_in = r_data_in;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_err     = r_rsp_err;
  assign bus.rsp_rdata   = r_rsp_rdata;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_write     <= 1'b0;
      r_wdata     <= 8'h00;
      r_start_n   <= 1'b1;
      r_data_in   <= 8'h00;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 8'h00;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid && w_req_ready) begin
            r_write   <= bus.req_write;
            r_wdata   <= bus.req_wdata;
            r_data_in <= {bus.req_addr, ~bus.req_write};
            r_cnt     <= '0;
            r_start_n <= 1'b0;
            r_state   <= S_A_START;
          end
        end
        // Busy rising on the timeout cycle still counts as a successful start.
        S_A_START, S_D_START: begin
          if (bus.spi_busy) begin
            r_start_n <= 1'b1;
            r_cnt     <= '0;
            r_state   <= (r_state == S_A_START) ? S_A_WAIT : S_D_WAIT;
          end else if (r_cnt == START_LAST) begin
            r_start_n <= 1'b1;
            r_state   <= S_ERROR;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_A_WAIT, S_D_WAIT: begin
          if (!bus.spi_busy) begin
            r_cnt   <= '0;
            r_state <= (r_state == S_A_WAIT) ? S_GAP : S_DONE;
          end else if (r_cnt == BUSY_LAST) begin
            r_state <= S_ERROR;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_cnt     <= '0;
            r_data_in <= r_write ? r_wdata : 8'h00;
            r_start_n <= 1'b0;
            r_state   <= S_D_START;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= bus.spi_data_out;
          r_state     <= S_IDLE;
        end
        S_ERROR: begin
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b1;
          r_rsp_rdata <= 8'h00;
          r_start_n   <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_sequencer.sv
// Bench for spi_reg_sequencer with a behavioural spi_master model and byte/response scoreboards.
module tb_spi_reg_sequencer;
  localparam int unsigned GAP = 4;
  localparam int unsigned ST  = 8;
  localparam int unsigned BT  = 64;
  localparam int BYTE_LEN     = 5;

  logic clk;
  logic reset;
  spi_reg_sequencer_if bus();

  spi_reg_sequencer #(
    .GAP_CYCLES(GAP), .START_TIMEOUT(ST), .BUSY_TIMEOUT(BT), .CNT_W(32)
  ) dut (
    .CLOCK_50(clk),
    .reset   (reset),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  // spi_master model: busy rises rise_dly cycles after start seen low, lasts BYTE_LEN cycles.
  logic       m_busy;
  logic [7:0] m_dout;
  int         m_dly;
  int         m_len;
  bit         model_en;
  int         rise_dly;
  logic       busy_force;
  logic [7:0] miso_val;
  logic [7:0] obs_q[$];
  logic [7:0] exp_q[$];
  logic [8:0] rsp_q[$];
  int         low_cycles;
  int         start_pulses;
  logic       prev_start_n;

  assign bus.spi_busy     = m_busy | busy_force;
  assign bus.spi_data_out = m_dout;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0;
      m_dout <= 8'h00;
      m_dly  <= 0;
      m_len  <= 0;
    end else if (m_busy) begin
      if (m_len == BYTE_LEN - 1) begin
        m_busy <= 1'b0;
        m_dout <= miso_val;
        m_len  <= 0;
      end else begin
        m_len <= m_len + 1;
      end
    end else if (!bus.spi_start_n && model_en) begin
      if (m_dly == rise_dly) begin
        m_busy <= 1'b1;
        m_dly  <= 0;
        obs_q.push_back(bus.spi_data_in);
      end else begin
        m_dly <= m_dly + 1;
      end
    end else begin
      m_dly <= 0;
    end
  end

  always @(posedge clk) begin
    prev_start_n <= bus.spi_start_n;
    if (!bus.spi_start_n) low_cycles <= low_cycles + 1;
    if (prev_start_n && !bus.spi_start_n) start_pulses <= start_pulses + 1;
  end

  task automatic issue(input logic wr, input logic [6:0] a, input logic [7:0] d, output bit ok);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_wdata = d;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (bus.req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output bit got, output logic err, output logic [7:0] rd);
    got = 1'b0;
    err = 1'b0;
    rd  = 8'h00;
    for (int i = 0; i < 2000; i++) begin
      if (bus.rsp_valid) begin
        got = 1'b1;
        err = bus.rsp_err;
        rd  = bus.rsp_rdata;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.spi_start_n, bus.spi_data_in, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.seq_busy}
        !== {1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      failures++;
      $display("FAIL reset_outputs got start_n=%b din=%h v=%b e=%b rd=%h sb=%b exp 1 00 0 0 00 0",
               bus.spi_start_n, bus.spi_data_in, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.seq_busy);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=1", bus.req_ready);
    end
  endtask

  task automatic test_write();
    bit ok, got;
    logic err;
    logic [7:0] rd, ob, eb;
    logic [8:0] e;
    int p0;
    exp_q.delete(); rsp_q.delete(); obs_q.delete();
    miso_val = 8'hC3;
    p0 = start_pulses;
    exp_q.push_back(8'h24); exp_q.push_back(8'h26);
    rsp_q.push_back({1'b0, 8'hC3});
    issue(1'b1, 7'h12, 8'h26, ok);
    checks++;
    if (bus.seq_busy !== 1'b1 || bus.req_ready !== 1'b0) begin
      failures++;
      $display("FAIL wr_busy got seq_busy=%b ready=%b exp 1 0", bus.seq_busy, bus.req_ready);
    end
    wait_rsp(got, err, rd);
    e = rsp_q.pop_front();
    checks++;
    if (!ok || !got || {err, rd} !== e) begin
      failures++;
      $display("FAIL wr_rsp got ok=%b got=%b rsp=%h exp=%h", ok, got, {err, rd}, e);
    end
    while (exp_q.size() > 0) begin
      eb = exp_q.pop_front();
      ob = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      checks++;
      if (ob !== eb) begin
        failures++;
        $display("FAIL wr_byte got=%h exp=%h", ob, eb);
      end
    end
    checks++;
    if (start_pulses - p0 != 2) begin
      failures++;
      $display("FAIL wr_start_pulses got=%0d exp=2", start_pulses - p0);
    end
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 8'hC3) begin
      failures++;
      $display("FAIL wr_rsp_hold got v=%b rd=%h exp 0 c3", bus.rsp_valid, bus.rsp_rdata);
    end
  endtask

  task automatic test_read();
    bit ok, got;
    logic err;
    logic [7:0] rd, ob, eb;
    logic [8:0] e;
    exp_q.delete(); rsp_q.delete(); obs_q.delete();
    miso_val = 8'h5A;
    exp_q.push_back(8'h0B); exp_q.push_back(8'h00);
    rsp_q.push_back({1'b0, 8'h5A});
    issue(1'b0, 7'h05, 8'hFF, ok);
    wait_rsp(got, err, rd);
    e = rsp_q.pop_front();
    checks++;
    if (!ok || !got || {err, rd} !== e) begin
      failures++;
      $display("FAIL rd_rsp got ok=%b got=%b rsp=%h exp=%h", ok, got, {err, rd}, e);
    end
    while (exp_q.size() > 0) begin
      eb = exp_q.pop_front();
      ob = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      checks++;
      if (ob !== eb) begin
        failures++;
        $display("FAIL rd_byte got=%h exp=%h", ob, eb);
      end
    end
  endtask

  task automatic test_start_timeout();
    bit ok, got;
    logic err;
    logic [7:0] rd;
    logic [8:0] e;
    int l0, p0;
    exp_q.delete(); rsp_q.delete(); obs_q.delete();
    model_en = 1'b0;
    l0 = low_cycles;
    p0 = start_pulses;
    rsp_q.push_back({1'b1, 8'h00});
    issue(1'b1, 7'h12, 8'h26, ok);
    wait_rsp(got, err, rd);
    e = rsp_q.pop_front();
    checks++;
    if (!ok || !got || {err, rd} !== e) begin
      failures++;
      $display("FAIL to_rsp got ok=%b got=%b rsp=%h exp=%h", ok, got, {err, rd}, e);
    end
    checks++;
    if (low_cycles - l0 != 8 || start_pulses - p0 != 1) begin
      failures++;
      $display("FAIL to_start_low got=%0d cycles/%0d pulses exp 8/1", low_cycles - l0, start_pulses - p0);
    end
    model_en = 1'b1;
    miso_val = 8'h11;
    rsp_q.push_back({1'b0, 8'h11});
    issue(1'b0, 7'h33, 8'h00, ok);
    wait_rsp(got, err, rd);
    e = rsp_q.pop_front();
    checks++;
    if (!ok || !got || {err, rd} !== e) begin
      failures++;
      $display("FAIL to_recover got ok=%b got=%b rsp=%h exp=%h", ok, got, {err, rd}, e);
    end
    obs_q.delete();
  endtask

  task automatic test_busy_wins();
    bit ok, got;
    logic err;
    logic [7:0] rd;
    logic [8:0] e;
    rsp_q.delete(); obs_q.delete();
    miso_val = 8'h77;
    rise_dly = 6;
    rsp_q.push_back({1'b0, 8'h77});
    issue(1'b1, 7'h12, 8'h26, ok);
    wait_rsp(got, err, rd);
    e = rsp_q.pop_front();
    checks++;
    if (!ok || !got || {err, rd} !== e) begin
      failures++;
      $display("FAIL busy_on_limit got ok=%b got=%b rsp=%h exp=%h", ok, got, {err, rd}, e);
    end
    rise_dly = 7;
    rsp_q.push_back({1'b1, 8'h00});
    issue(1'b1, 7'h12, 8'h26, ok);
    wait_rsp(got, err, rd);
    e = rsp_q.pop_front();
    checks++;
    if (!ok || !got || {err, rd} !== e) begin
      failures++;
      $display("FAIL busy_past_limit got ok=%b got=%b rsp=%h exp=%h", ok, got, {err, rd}, e);
    end
    rise_dly = 0;
    obs_q.delete();
  endtask

  task automatic test_back_to_back();
    bit got, got2, acc, early;
    logic err;
    logic [7:0] rd, ob, eb;
    logic [8:0] e;
    exp_q.delete(); rsp_q.delete(); obs_q.delete();
    miso_val = 8'h3C;
    exp_q.push_back(8'h24); exp_q.push_back(8'h26);
    exp_q.push_back(8'h26); exp_q.push_back(8'h27);
    rsp_q.push_back({1'b0, 8'h3C}); rsp_q.push_back({1'b0, 8'h3C});
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 7'h12; bus.req_wdata = 8'h26;
    acc = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (bus.req_ready) begin
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    bus.req_addr = 7'h13; bus.req_wdata = 8'h27;
    got = 1'b0; early = 1'b0; err = 1'b0; rd = 8'h00;
    for (int i = 0; i < 500; i++) begin
      if (bus.rsp_valid) begin
        got = 1'b1; err = bus.rsp_err; rd = bus.rsp_rdata;
        break;
      end
      if (bus.req_ready) early = 1'b1;
      @(negedge clk);
    end
    e = rsp_q.pop_front();
    checks++;
    if (!acc || !got || {err, rd} !== e) begin
      failures++;
      $display("FAIL b2b_rsp1 got acc=%b got=%b rsp=%h exp=%h", acc, got, {err, rd}, e);
    end
    checks++;
    if (early !== 1'b0 || bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ready got early=%b ready_after_done=%b exp 0 1", early, bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    checks++;
    if (bus.seq_busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_second_accept got seq_busy=%b exp=1", bus.seq_busy);
    end
    wait_rsp(got2, err, rd);
    e = rsp_q.pop_front();
    checks++;
    if (!got2 || {err, rd} !== e) begin
      failures++;
      $display("FAIL b2b_rsp2 got got=%b rsp=%h exp=%h", got2, {err, rd}, e);
    end
    while (exp_q.size() > 0) begin
      eb = exp_q.pop_front();
      ob = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      checks++;
      if (ob !== eb) begin
        failures++;
        $display("FAIL b2b_byte got=%h exp=%h", ob, eb);
      end
    end
  endtask

  task automatic test_busy_idle();
    bit ok, got, bad;
    logic err;
    logic [7:0] rd;
    logic [8:0] e;
    rsp_q.delete(); obs_q.delete();
    miso_val = 8'h99;
    busy_force = 1'b1;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 7'h40; bus.req_wdata = 8'h00;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.req_ready !== 1'b0 || bus.spi_start_n !== 1'b1 || bus.seq_busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL idle_busy_block got ready=%b start_n=%b exp 0 1", bus.req_ready, bus.spi_start_n);
    end
    busy_force = 1'b0;
    rsp_q.push_back({1'b0, 8'h99});
    issue(1'b0, 7'h40, 8'h00, ok);
    wait_rsp(got, err, rd);
    e = rsp_q.pop_front();
    checks++;
    if (!ok || !got || {err, rd} !== e) begin
      failures++;
      $display("FAIL idle_busy_then_go got ok=%b got=%b rsp=%h exp=%h", ok, got, {err, rd}, e);
    end
  endtask

  task automatic test_reset_mid();
    bit ok, found, seen;
    obs_q.delete();
    issue(1'b1, 7'h12, 8'h26, ok);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.seq_busy && bus.spi_start_n && bus.spi_busy) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!ok || !found) begin
      failures++;
      $display("FAIL rst_mid_reach got ok=%b found=%b exp 1 1", ok, found);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.spi_start_n, bus.spi_data_in, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.seq_busy}
        !== {1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      failures++;
      $display("FAIL rst_mid_outputs got start_n=%b din=%h v=%b e=%b rd=%h sb=%b exp 1 00 0 0 00 0",
               bus.spi_start_n, bus.spi_data_in, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.seq_busy);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_ready got=%b exp=1", bus.req_ready);
    end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.rsp_valid) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_no_rsp got=%b exp=0", seen);
    end
  endtask

  initial begin
    reset         = 1'b1;
    model_en      = 1'b1;
    rise_dly      = 0;
    busy_force    = 1'b0;
    miso_val      = 8'h00;
    low_cycles    = 0;
    start_pulses  = 0;
    prev_start_n  = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 7'h00;
    bus.req_wdata = 8'h00;
    @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_start_timeout();
    test_busy_wins();
    test_back_to_back();
    test_busy_idle();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
